// File: rtl/mvm_sparse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mvm_sparse_ctrl
// Description : Sparse MVM sequencer: loads a dense vector, accumulates
//               (row, col, value) triplets, streams the saturated result.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_sparse_ctrl #(
    parameter int DIM     = 4,
    parameter int DW      = 8,
    parameter int ACCW    = 18,
    parameter int MAX_NNZ = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DW-1:0]           value,
    input  logic [$clog2(DIM)-1:0]  row,
    input  logic [$clog2(DIM)-1:0]  col,
    input  logic                    sending_cpu,
    input  logic                    done_list,
    output logic                    fetch_ready,
    output logic                    sending_out,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(DIM)-1:0]  out_idx,
    output logic                    busy
);

    localparam int                c_iw       = $clog2(DIM);
    localparam int                c_cw       = $clog2(MAX_NNZ + 1);
    localparam logic [c_iw-1:0]   c_last_idx = c_iw'(DIM - 1);
    localparam logic [c_cw-1:0]   c_max_nnz  = c_cw'(MAX_NNZ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_VEC = 2'd1,
        FETCH    = 2'd2,
        SEND     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_q;
    logic [DW-1:0]      r_vec [DIM];
    logic [ACCW-1:0]    r_acc [DIM];
    logic [c_iw-1:0]    r_vec_idx;
    logic [c_cw-1:0]    r_nnz_cnt;

    logic               w_vec_wr;
    logic               w_trip_acc;
    logic [c_cw-1:0]    w_nnz_nxt;
    logic [2*DW-1:0]    w_prod;
    logic [ACCW-1:0]    w_acc_nxt [DIM];
    logic [c_iw-1:0]    w_out_idx_nxt;
    logic [ACCW-1:0]    w_sat_src;

    assign w_vec_wr   = (r_state == LOAD_VEC) && start && sending_cpu;
    assign w_trip_acc = (r_state == FETCH) && start && sending_cpu;
    assign w_nnz_nxt  = r_nnz_cnt + c_cw'(w_trip_acc);
    assign w_prod     = value * r_vec[col];

    // Accumulator view including this cycle's triplet, so a triplet accepted
    // on the terminating edge is already visible in the first output element.
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_trip_acc) begin
            w_acc_nxt[row] = r_acc[row] + ACCW'(w_prod);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_out_idx_nxt = '0;
        case (r_state)
            IDLE: begin
                if (start && !r_start_q) w_state_nxt = LOAD_VEC;
            end
            LOAD_VEC: begin
                if (!start)                                   w_state_nxt = IDLE;
                else if (w_vec_wr && r_vec_idx == c_last_idx) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (!start)                                      w_state_nxt = IDLE;
                else if (done_list || w_nnz_nxt == c_max_nnz)    w_state_nxt = SEND;
            end
            SEND: begin
                if (!start || out_idx == c_last_idx) w_state_nxt = IDLE;
                else                                 w_out_idx_nxt = out_idx + c_iw'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_sat_src = w_acc_nxt[w_out_idx_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_start_q   <= 1'b0;
            r_vec_idx   <= '0;
            r_nnz_cnt   <= '0;
            fetch_ready <= 1'b0;
            sending_out <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            busy        <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                r_vec[i] <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;

            if (r_state == IDLE && w_state_nxt == LOAD_VEC) begin
                r_vec_idx <= '0;
                r_nnz_cnt <= '0;
                for (int i = 0; i < DIM; i++) begin
                    r_acc[i] <= '0;
                end
            end else begin
                if (w_vec_wr) begin
                    r_vec[r_vec_idx] <= value;
                    r_vec_idx        <= r_vec_idx + c_iw'(1);
                end
                if (w_trip_acc) begin
                    r_acc     <= w_acc_nxt;
                    r_nnz_cnt <= w_nnz_nxt;
                end
            end

            fetch_ready <= (w_state_nxt == LOAD_VEC) || (w_state_nxt == FETCH);
            sending_out <= (w_state_nxt == SEND);
            busy        <= (w_state_nxt != IDLE);

            if (w_state_nxt == SEND) begin
                out_idx  <= w_out_idx_nxt;
                out_data <= (|w_sat_src[ACCW-1:DW]) ? '1 : w_sat_src[DW-1:0];
            end else begin
                out_idx  <= '0;
                out_data <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvm_sparse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvm_sparse_ctrl
// Description : Scoreboard bench for mvm_sparse_ctrl with directed and
//               randomized jobs checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_sparse_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] value = '0;
    logic [1:0] row = '0;
    logic [1:0] col = '0;
    logic       sending_cpu = 1'b0;
    logic       done_list = 1'b0;
    logic       fetch_ready;
    logic       sending_out;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       busy;

    mvm_sparse_ctrl #(.DIM(4), .DW(8), .ACCW(18), .MAX_NNZ(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .value       (value),
        .row         (row),
        .col         (col),
        .sending_cpu (sending_cpu),
        .done_list   (done_list),
        .fetch_ready (fetch_ready),
        .sending_out (sending_out),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int data; } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_vec [4];
    logic [1:0] t_row [32];
    logic [1:0] t_col [32];
    logic [7:0] t_val [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every presented element must match the head of the scoreboard
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (sending_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sending_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_idx", 32'(out_idx), 32'(e.idx));
                    check("out_data", 32'(out_data), 32'(e.data));
                end
            end else begin
                check("idle_out_zero", {22'd0, out_idx, out_data}, 32'd0);
            end
        end
    end

    task automatic push_expected(input longint acc [4]);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.idx  = k;
            e.data = (acc[k] > 255) ? 255 : int'(acc[k]);
            exp_q.push_back(e);
        end
    endtask

    // Runs a whole job: vector load, n triplets, termination, drain
    task automatic run_job(input int n, input bit simul, input bit gaps);
        longint acc [4];
        bit     ended;
        bit     term;
        int     waited;
        for (int k = 0; k < 4; k++) acc[k] = 0;
        ended = 1'b0;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
            check("fetch_ready_load", 32'(fetch_ready), 32'd1);
            value = m_vec[k];
            row = 2'($urandom_range(0, 3));
            col = 2'($urandom_range(0, 3));
            done_list = 1'($urandom_range(0, 1));
            sending_cpu = 1'b1;
            @(negedge clk);
            sending_cpu = 1'b0;
            done_list = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && i < 16) repeat ($urandom_range(0, 1)) @(negedge clk);
            check("fetch_ready_fetch", 32'(fetch_ready), (i < 16) ? 32'd1 : 32'd0);
            row = t_row[i];
            col = t_col[i];
            value = t_val[i];
            sending_cpu = 1'b1;
            term = 1'b0;
            if (i < 16) begin
                acc[t_row[i]] += longint'(t_val[i]) * longint'(m_vec[t_col[i]]);
                term = (i == 15) || (simul && i == n - 1);
            end
            if (term) begin
                done_list = simul && (i == n - 1);
                push_expected(acc);
            end
            @(negedge clk);
            sending_cpu = 1'b0;
            done_list = 1'b0;
            if (term) begin
                check("first_out_timing", 32'(sending_out), 32'd1);
                ended = 1'b1;
            end
        end
        if (!ended) begin
            done_list = 1'b1;
            push_expected(acc);
            @(negedge clk);
            done_list = 1'b0;
            check("first_out_timing", 32'(sending_out), 32'd1);
        end
        waited = 0;
        while (busy && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        check("job_end_busy", 32'(busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_outputs", {19'd0, fetch_ready, sending_out, busy, out_idx, out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {30'd0, busy, fetch_ready}, 32'd0);

        // Basic job
        m_vec[0] = 8'd1; m_vec[1] = 8'd2; m_vec[2] = 8'd3; m_vec[3] = 8'd4;
        t_row[0] = 2'd0; t_col[0] = 2'd0; t_val[0] = 8'd5;
        t_row[1] = 2'd1; t_col[1] = 2'd3; t_val[1] = 8'd2;
        t_row[2] = 2'd3; t_col[2] = 2'd1; t_val[2] = 8'd10;
        run_job(3, 1'b0, 1'b0);

        // start held high after SEND must not restart
        repeat (6) @(negedge clk);
        check("no_restart_busy", 32'(busy), 32'd0);

        // Duplicates and saturation
        m_vec[0] = 8'd200; m_vec[1] = 8'd200; m_vec[2] = 8'd0; m_vec[3] = 8'd0;
        t_row[0] = 2'd2; t_col[0] = 2'd0; t_val[0] = 8'd200;
        t_row[1] = 2'd2; t_col[1] = 2'd1; t_val[1] = 8'd200;
        t_row[2] = 2'd2; t_col[2] = 2'd0; t_val[2] = 8'd1;
        run_job(3, 1'b0, 1'b0);

        // Simultaneous sending_cpu and done_list
        m_vec[0] = 8'd9; m_vec[1] = 8'd4; m_vec[2] = 8'd3; m_vec[3] = 8'd6;
        t_row[0] = 2'd1; t_col[0] = 2'd2; t_val[0] = 8'd7;
        run_job(1, 1'b1, 1'b0);

        // MAX_NNZ auto-termination, 17th triplet dropped
        m_vec[0] = 8'd1; m_vec[1] = 8'd0; m_vec[2] = 8'd0; m_vec[3] = 8'd0;
        for (int i = 0; i < 17; i++) begin
            t_row[i] = 2'd0; t_col[i] = 2'd0; t_val[i] = 8'd1;
        end
        run_job(17, 1'b0, 1'b0);

        // Abort during LOAD_VEC
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            value = 8'(k + 3);
            sending_cpu = 1'b1;
            @(negedge clk);
        end
        sending_cpu = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_idle", {30'd0, busy, fetch_ready}, 32'd0);
        repeat (5) @(negedge clk);

        // Empty list
        m_vec[0] = 8'd11; m_vec[1] = 8'd22; m_vec[2] = 8'd33; m_vec[3] = 8'd44;
        run_job(0, 1'b0, 1'b0);

        // Reset mid-FETCH
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            value = 8'd50;
            row = 2'(k);
            col = 2'(k);
            sending_cpu = 1'b1;
            @(negedge clk);
        end
        sending_cpu = 1'b0;
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("async_reset_outputs", {19'd0, fetch_ready, sending_out, busy, out_idx, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);

        // Randomized jobs
        for (int j = 0; j < 24; j++) begin
            int  n;
            bit  simul;
            for (int k = 0; k < 4; k++) m_vec[k] = 8'($urandom_range(0, 255));
            n = $urandom_range(0, 18);
            simul = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < n; i++) begin
                t_row[i] = 2'($urandom_range(0, 3));
                t_col[i] = 2'($urandom_range(0, 3));
                t_val[i] = 8'($urandom_range(0, 255));
            end
            run_job(n, simul, 1'b1);
        end

        start = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
